// File: rtl/mor1kx_wb_stage_cappuccino.sv
// Ctrl/writeback result stage: carries the GPR write from execute through ctrl to wb and captures late LSU/MUL/SPR results.
// Latency: execute->ctrl_* 1 edge, ctrl->wb_* 1 edge, late valid->ctrl_ready_o 0 cycles (combinational bypass).
// Backpressure: ctrl_ready_o low while a late result is owed; an advance while not ready drops the write.
module mor1kx_wb_stage_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter     FEATURE_R0_PROTECT   = "ENABLED"
) (
  input  logic                            clk,
  input  logic                            rst,

  input  logic                            padv_execute_i,
  input  logic                            padv_ctrl_i,
  input  logic                            pipeline_flush_i,

  input  logic                            execute_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] execute_rfd_adr_i,
  input  logic [2:0]                      execute_sel_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] execute_pc_i,

  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
  input  logic                            ctrl_exception_i,

  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i,
  input  logic                            lsu_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] mul_result_i,
  input  logic                            mul_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_result_i,
  input  logic                            spr_valid_i,

  output logic                            ctrl_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_o,
  output logic                            ctrl_ready_o,

  output logic                            wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] result_o
);

  localparam int W  = OPTION_OPERAND_WIDTH;
  localparam int AW = OPTION_RF_ADDR_WIDTH;

  localparam bit R0_PROTECT = (FEATURE_R0_PROTECT == "ENABLED");

  // Result source encodings; 5-7 fall back to the ALU.
  localparam logic [2:0] SEL_LSU  = 3'd1;
  localparam logic [2:0] SEL_MUL  = 3'd2;
  localparam logic [2:0] SEL_SPR  = 3'd3;
  localparam logic [2:0] SEL_LINK = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no late result owed by the ctrl instruction
    ST_WAIT = 2'd1,  // late result owed, hold register not yet loaded
    ST_HELD = 2'd2   // late result captured, waiting for padv_ctrl_i
  } state_t;

  state_t         state;
  logic [2:0]     ctrl_sel;
  logic [W-1:0]   ctrl_link;
  logic [W-1:0]   hold;

  logic           exec_late;
  logic           late_vld;
  logic [W-1:0]   late_dat;
  logic [W-1:0]   wb_dat;
  logic           wb_we;

  // A source is late when its data only arrives while the instruction sits in ctrl.
  assign exec_late = (execute_sel_i == SEL_LSU) ||
                     (execute_sel_i == SEL_MUL) ||
                     (execute_sel_i == SEL_SPR);

  // Pick the valid/data pair that matches the ctrl instruction's source; others are ignored.
  always_comb begin
    late_vld = 1'b0;
    late_dat = '0;
    case (ctrl_sel)
      SEL_LSU: begin
        late_vld = lsu_valid_i;
        late_dat = lsu_result_i;
      end
      SEL_MUL: begin
        late_vld = mul_valid_i;
        late_dat = mul_result_i;
      end
      SEL_SPR: begin
        late_vld = spr_valid_i;
        late_dat = spr_result_i;
      end
      default: begin
        late_vld = 1'b0;
        late_dat = '0;
      end
    endcase
  end

  // Ready unless still owed; a matching valid this cycle bypasses the hold register.
  assign ctrl_ready_o = (state != ST_WAIT) || late_vld;

  // Write-back data mux: live late data wins over the hold register only while still waiting.
  always_comb begin
    wb_dat = ctrl_alu_result_i;
    case (ctrl_sel)
      SEL_LSU, SEL_MUL, SEL_SPR: begin
        if (state == ST_WAIT && late_vld)
          wb_dat = late_dat;
        else
          wb_dat = hold;
      end
      SEL_LINK: wb_dat = ctrl_link;
      default:  wb_dat = ctrl_alu_result_i;
    endcase
  end

  // Write strobe qualifiers: not owed, not excepting, and never r0 when protected.
  assign wb_we = ctrl_rf_wb_o && ctrl_ready_o && !ctrl_exception_i &&
                 !(R0_PROTECT && (ctrl_rfd_adr_o == '0));

  // Ctrl slot: loaded on execute advance; flush only kills the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_rf_wb_o   <= 1'b0;
      ctrl_rfd_adr_o <= '0;
      ctrl_sel       <= '0;
      ctrl_link      <= '0;
    end else if (pipeline_flush_i) begin
      ctrl_rf_wb_o   <= 1'b0;
    end else if (padv_execute_i) begin
      ctrl_rf_wb_o   <= execute_rf_wb_i;
      ctrl_rfd_adr_o <= execute_rfd_adr_i;
      ctrl_sel       <= execute_sel_i;
      ctrl_link      <= execute_pc_i + W'(8);
    end
  end

  // Late-result FSM; a new instruction entering ctrl takes precedence over leaving it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hold  <= '0;
    end else if (pipeline_flush_i) begin
      state <= ST_IDLE;
    end else if (padv_execute_i) begin
      state <= (exec_late && execute_rf_wb_i) ? ST_WAIT : ST_IDLE;
    end else if (padv_ctrl_i) begin
      // Covers the normal exit and the advance-while-not-ready error case.
      state <= ST_IDLE;
    end else if (state == ST_WAIT && late_vld) begin
      hold  <= late_dat;
      state <= ST_HELD;
    end
  end

  // Writeback register: strobe is a single-cycle pulse, address and data hold between advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_rf_wb_o   <= 1'b0;
      wb_rfd_adr_o <= '0;
      result_o     <= '0;
    end else begin
      wb_rf_wb_o <= 1'b0;
      if (!pipeline_flush_i && padv_ctrl_i) begin
        wb_rf_wb_o   <= wb_we;
        wb_rfd_adr_o <= ctrl_rfd_adr_o;
        result_o     <= wb_dat;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_wb_stage_cappuccino.sv
// Directed bench for the cappuccino ctrl/writeback result stage.
module tb_mor1kx_wb_stage_cappuccino;

  logic        clk;
  logic        rst;
  logic        padv_execute_i;
  logic        padv_ctrl_i;
  logic        pipeline_flush_i;
  logic        execute_rf_wb_i;
  logic [4:0]  execute_rfd_adr_i;
  logic [2:0]  execute_sel_i;
  logic [31:0] execute_pc_i;
  logic [31:0] ctrl_alu_result_i;
  logic        ctrl_exception_i;
  logic [31:0] lsu_result_i;
  logic        lsu_valid_i;
  logic [31:0] mul_result_i;
  logic        mul_valid_i;
  logic [31:0] spr_result_i;
  logic        spr_valid_i;
  logic        ctrl_rf_wb_o;
  logic [4:0]  ctrl_rfd_adr_o;
  logic        ctrl_ready_o;
  logic        wb_rf_wb_o;
  logic [4:0]  wb_rfd_adr_o;
  logic [31:0] result_o;

  int n_chk;
  int n_fail;

  mor1kx_wb_stage_cappuccino #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5),
    .FEATURE_R0_PROTECT("ENABLED")
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .padv_execute_i    (padv_execute_i),
    .padv_ctrl_i       (padv_ctrl_i),
    .pipeline_flush_i  (pipeline_flush_i),
    .execute_rf_wb_i   (execute_rf_wb_i),
    .execute_rfd_adr_i (execute_rfd_adr_i),
    .execute_sel_i     (execute_sel_i),
    .execute_pc_i      (execute_pc_i),
    .ctrl_alu_result_i (ctrl_alu_result_i),
    .ctrl_exception_i  (ctrl_exception_i),
    .lsu_result_i      (lsu_result_i),
    .lsu_valid_i       (lsu_valid_i),
    .mul_result_i      (mul_result_i),
    .mul_valid_i       (mul_valid_i),
    .spr_result_i      (spr_result_i),
    .spr_valid_i       (spr_valid_i),
    .ctrl_rf_wb_o      (ctrl_rf_wb_o),
    .ctrl_rfd_adr_o    (ctrl_rfd_adr_o),
    .ctrl_ready_o      (ctrl_ready_o),
    .wb_rf_wb_o        (wb_rf_wb_o),
    .wb_rfd_adr_o      (wb_rfd_adr_o),
    .result_o          (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    padv_execute_i    = 1'b0;
    padv_ctrl_i       = 1'b0;
    pipeline_flush_i  = 1'b0;
    ctrl_exception_i  = 1'b0;
    lsu_valid_i       = 1'b0;
    mul_valid_i       = 1'b0;
    spr_valid_i       = 1'b0;
  endtask

  // Present one instruction to execute and advance it into ctrl.
  task automatic issue(input logic wb, input logic [4:0] adr, input logic [2:0] sel, input logic [31:0] pc);
    execute_rf_wb_i   = wb;
    execute_rfd_adr_i = adr;
    execute_sel_i     = sel;
    execute_pc_i      = pc;
    padv_execute_i    = 1'b1;
    step();
    quiet();
  endtask

  // Advance ctrl into wb with the given ALU result.
  task automatic retire(input logic [31:0] alu);
    ctrl_alu_result_i = alu;
    padv_ctrl_i       = 1'b1;
    step();
    quiet();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    quiet();
    execute_rf_wb_i   = 1'b0;
    execute_rfd_adr_i = '0;
    execute_sel_i     = '0;
    execute_pc_i      = '0;
    ctrl_alu_result_i = '0;
    lsu_result_i      = '0;
    mul_result_i      = '0;
    spr_result_i      = '0;

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_ctrl_rf_wb", 32'(ctrl_rf_wb_o), 32'd0);
    check("rst_ctrl_adr",   32'(ctrl_rfd_adr_o), 32'd0);
    check("rst_ready",      32'(ctrl_ready_o), 32'd1);
    check("rst_wb_rf_wb",   32'(wb_rf_wb_o), 32'd0);
    check("rst_wb_adr",     32'(wb_rfd_adr_o), 32'd0);
    check("rst_result",     result_o, 32'd0);

    // 1: ALU write
    issue(1'b1, 5'd3, 3'd0, 32'h100);
    check("alu_ctrl_rf_wb", 32'(ctrl_rf_wb_o), 32'd1);
    check("alu_ctrl_adr",   32'(ctrl_rfd_adr_o), 32'd3);
    check("alu_ready",      32'(ctrl_ready_o), 32'd1);
    retire(32'h1234);
    check("alu_wb_we",      32'(wb_rf_wb_o), 32'd1);
    check("alu_wb_adr",     32'(wb_rfd_adr_o), 32'd3);
    check("alu_result",     result_o, 32'h1234);
    step();
    check("alu_we_pulse",   32'(wb_rf_wb_o), 32'd0);
    check("alu_result_hold", result_o, 32'h1234);

    // 2: load stall, data arrives three cycles after entering ctrl
    issue(1'b1, 5'd5, 3'd1, 32'h200);
    check("ld_ready_low0",  32'(ctrl_ready_o), 32'd0);
    step();
    step();
    check("ld_ready_low2",  32'(ctrl_ready_o), 32'd0);
    lsu_result_i = 32'hDEADBEEF;
    lsu_valid_i  = 1'b1;
    #1;
    check("ld_ready_bypass", 32'(ctrl_ready_o), 32'd1);
    step();
    lsu_valid_i  = 1'b0;
    lsu_result_i = 32'h0;
    #1;
    check("ld_ready_held",  32'(ctrl_ready_o), 32'd1);
    step();
    retire(32'h5555_0000);
    check("ld_wb_we",       32'(wb_rf_wb_o), 32'd1);
    check("ld_wb_adr",      32'(wb_rfd_adr_o), 32'd5);
    check("ld_result",      result_o, 32'hDEADBEEF);

    // 3: link address wraps
    issue(1'b1, 5'd9, 3'd4, 32'hFFFFFFFC);
    retire(32'h0);
    check("link_wb_we",     32'(wb_rf_wb_o), 32'd1);
    check("link_wb_adr",    32'(wb_rfd_adr_o), 32'd9);
    check("link_result",    result_o, 32'h00000004);

    // 4a: r0 write suppressed, data still moves
    issue(1'b1, 5'd0, 3'd0, 32'h0);
    retire(32'h55);
    check("r0_wb_we",       32'(wb_rf_wb_o), 32'd0);
    check("r0_result",      result_o, 32'h55);

    // 4b: exception drops the write
    issue(1'b1, 5'd7, 3'd0, 32'h0);
    ctrl_exception_i = 1'b1;
    retire(32'h77);
    check("exc_wb_we",      32'(wb_rf_wb_o), 32'd0);
    check("exc_wb_adr",     32'(wb_rfd_adr_o), 32'd7);

    // 4c: advancing while a mul result is owed
    issue(1'b1, 5'd6, 3'd2, 32'h0);
    check("mul_ready_low",  32'(ctrl_ready_o), 32'd0);
    retire(32'h66);
    check("noready_wb_we",  32'(wb_rf_wb_o), 32'd0);
    check("noready_idle",   32'(ctrl_ready_o), 32'd1);

    // 5: flush during WAIT beats a same-cycle execute advance
    issue(1'b1, 5'd4, 3'd2, 32'h0);
    check("fl_wait",        32'(ctrl_ready_o), 32'd0);
    execute_rf_wb_i   = 1'b1;
    execute_rfd_adr_i = 5'd8;
    execute_sel_i     = 3'd2;
    padv_execute_i    = 1'b1;
    pipeline_flush_i  = 1'b1;
    step();
    quiet();
    check("fl_ctrl_rf_wb",  32'(ctrl_rf_wb_o), 32'd0);
    check("fl_ctrl_adr",    32'(ctrl_rfd_adr_o), 32'd4);
    check("fl_ready",       32'(ctrl_ready_o), 32'd1);
    check("fl_wb_we",       32'(wb_rf_wb_o), 32'd0);
    mul_result_i = 32'h00000BAD;
    mul_valid_i  = 1'b1;
    step();
    quiet();
    // A late instruction that does not write reads the hold register, which must not hold 0xBAD.
    issue(1'b0, 5'd10, 3'd2, 32'h0);
    check("fl_nowait_ready", 32'(ctrl_ready_o), 32'd1);
    retire(32'h0);
    check("fl_nocap_result", result_o, 32'hDEADBEEF);
    check("fl_nocap_we",    32'(wb_rf_wb_o), 32'd0);

    // 6: back-to-back, ALU leaves ctrl as a load enters
    issue(1'b1, 5'd1, 3'd0, 32'h0);
    execute_rf_wb_i   = 1'b1;
    execute_rfd_adr_i = 5'd2;
    execute_sel_i     = 3'd1;
    padv_execute_i    = 1'b1;
    retire(32'h1111);
    check("b2b_wb_we",      32'(wb_rf_wb_o), 32'd1);
    check("b2b_wb_adr",     32'(wb_rfd_adr_o), 32'd1);
    check("b2b_result",     result_o, 32'h1111);
    check("b2b_ctrl_adr",   32'(ctrl_rfd_adr_o), 32'd2);
    check("b2b_ready_low",  32'(ctrl_ready_o), 32'd0);
    lsu_result_i = 32'h2222;
    lsu_valid_i  = 1'b1;
    #1;
    check("b2b_bypass",     32'(ctrl_ready_o), 32'd1);
    retire(32'h9999);
    check("b2b_ld_we",      32'(wb_rf_wb_o), 32'd1);
    check("b2b_ld_adr",     32'(wb_rfd_adr_o), 32'd2);
    check("b2b_ld_result",  result_o, 32'h2222);

    // Reset while waiting ignores a valid in the reset cycle
    issue(1'b1, 5'd12, 3'd3, 32'h0);
    rst          = 1'b1;
    spr_result_i = 32'hABCD;
    spr_valid_i  = 1'b1;
    step();
    rst = 1'b0;
    quiet();
    #1;
    check("rst2_ready",     32'(ctrl_ready_o), 32'd1);
    check("rst2_ctrl_rf_wb", 32'(ctrl_rf_wb_o), 32'd0);
    check("rst2_result",    result_o, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
